// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : MEM-stage data-memory responder with wait states, pipeline
//               stall, single-cycle done pulse and illegal-access reporting.
//               Optional byte lanes when DMEM_BYTE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wrt,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
`ifdef DMEM_BYTE_EN
    input  logic        mem_byte,
`endif
    output logic [15:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_err,
    output logic        mem_stall
);

    localparam int c_AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_rdata;
    logic             r_done;
    logic             r_err;

    logic             r_wr;
    logic             r_byte;
    logic             r_lane;
    logic [c_AW-1:0]  r_idx;
    logic [15:0]      r_wdata;

    logic [15:0]      r_ram [DEPTH];

    logic             w_req;
    logic             w_byte_req;
    logic             w_oor;
    logic             w_illegal;
    logic             w_last;
    logic [15:0]      w_word;
    logic [15:0]      w_load_val;

`ifdef DMEM_BYTE_EN
    assign w_byte_req = mem_byte;
`else
    assign w_byte_req = 1'b0;
`endif

    assign w_req     = mem_rd | mem_wrt;
    assign w_oor     = ({1'b0, mem_addr[15:1]} >= 16'(DEPTH));
    assign w_illegal = (mem_rd & mem_wrt) | (mem_addr[0] & ~w_byte_req) | w_oor;
    assign w_last    = (r_state == S_ACCESS) && (r_cnt == '0);

    assign w_word     = r_ram[r_idx];
    assign w_load_val = !r_byte ? w_word :
                        (r_lane ? {8'h00, w_word[15:8]} : {8'h00, w_word[7:0]});

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_req) w_state_nxt = w_illegal ? S_RESP : S_ACCESS;
            S_ACCESS: if (r_cnt == '0) w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_stall = ((r_state == S_IDLE) && w_req) || (r_state == S_ACCESS);
    end

    assign mem_rdata = r_rdata;
    assign mem_done  = r_done;
    assign mem_err   = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= (w_state_nxt == S_RESP);
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_illegal) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_cnt <= CNT_W'(WAIT_STATES);
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (!r_wr) begin
                        r_rdata <= w_load_val;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request capture; only meaningful once a legal request is accepted
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && w_req && !w_illegal) begin
            r_wr    <= mem_wrt;
            r_byte  <= w_byte_req;
            r_lane  <= mem_addr[0];
            r_idx   <= mem_addr[c_AW:1];
            r_wdata <= mem_wdata;
        end
    end

    // RAM is never reset; a reset on the commit edge aborts the store
    always_ff @(posedge clk) begin
        if (!rst && w_last && r_wr) begin
            if (!r_byte) begin
                r_ram[r_idx] <= r_wdata;
            end else if (r_lane) begin
                r_ram[r_idx][15:8] <= r_wdata[7:0];
            end else begin
                r_ram[r_idx][7:0] <= r_wdata[7:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// Testbench for data_mem_responder: three instances (WAIT_STATES 1, 0, 15),
// table-driven vectors, hand-written corner sequences and randomized traffic.
module tb_data_mem_responder;

    localparam int DEPTH = 128;
    localparam int NU    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_s    [NU];
    logic        wrt_s   [NU];
    logic        byte_s  [NU];
    logic [15:0] addr_s  [NU];
    logic [15:0] wdata_s [NU];
    logic [15:0] rdata_s [NU];
    logic        done_s  [NU];
    logic        err_s   [NU];
    logic        stall_s [NU];

    int checks   = 0;
    int failures = 0;

    int          wsv [NU] = '{1, 0, 15};
    logic [15:0] mem_m   [NU][DEPTH];
    bit          known_m [NU][DEPTH];
    logic [15:0] last_m  [NU];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(1), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .mem_rd(rd_s[0]), .mem_wrt(wrt_s[0]),
        .mem_addr(addr_s[0]), .mem_wdata(wdata_s[0]),
`ifdef DMEM_BYTE_EN
        .mem_byte(byte_s[0]),
`endif
        .mem_rdata(rdata_s[0]), .mem_done(done_s[0]), .mem_err(err_s[0]),
        .mem_stall(stall_s[0]));

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .mem_rd(rd_s[1]), .mem_wrt(wrt_s[1]),
        .mem_addr(addr_s[1]), .mem_wdata(wdata_s[1]),
`ifdef DMEM_BYTE_EN
        .mem_byte(byte_s[1]),
`endif
        .mem_rdata(rdata_s[1]), .mem_done(done_s[1]), .mem_err(err_s[1]),
        .mem_stall(stall_s[1]));

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(15), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .mem_rd(rd_s[2]), .mem_wrt(wrt_s[2]),
        .mem_addr(addr_s[2]), .mem_wdata(wdata_s[2]),
`ifdef DMEM_BYTE_EN
        .mem_byte(byte_s[2]),
`endif
        .mem_rdata(rdata_s[2]), .mem_done(done_s[2]), .mem_err(err_s[2]),
        .mem_stall(stall_s[2]));

    typedef struct {
        int          u;
        logic        rd;
        logic        wrt;
        logic        byt;
        logic [15:0] a;
        logic [15:0] wd;
        int          dc;
        logic        e;
        logic [15:0] rdat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Reference behaviour: response latency, error flag and returned data
    function automatic void model(input int u, input logic rd, input logic wrt,
                                  input logic byt, input logic [15:0] a,
                                  input logic [15:0] wd, output int dc,
                                  output logic e, output logic [15:0] rexp);
        int w;
        bit ill;
        w   = int'(a) / 2;
        ill = (rd && wrt) || (a[0] && !byt) || (w >= DEPTH);
        if (ill) begin
            dc = 1;
            e  = 1'b1;
            last_m[u] = 16'h0000;
        end else begin
            dc = 2 + wsv[u];
            e  = 1'b0;
            if (wrt) begin
                if (!byt) begin
                    mem_m[u][w]   = wd;
                    known_m[u][w] = 1'b1;
                end else if (a[0]) begin
                    mem_m[u][w] = {wd[7:0], mem_m[u][w][7:0]};
                end else begin
                    mem_m[u][w] = {mem_m[u][w][15:8], wd[7:0]};
                end
            end else begin
                if (!byt)      last_m[u] = mem_m[u][w];
                else if (a[0]) last_m[u] = {8'h00, mem_m[u][w][15:8]};
                else           last_m[u] = {8'h00, mem_m[u][w][7:0]};
            end
        end
        rexp = last_m[u];
    endfunction

    // Called just after a rising edge; returns just after the edge ending RESP
    task automatic do_req(input int u, input logic rd, input logic wrt, input logic byt,
                          input logic [15:0] a, input logic [15:0] wd, input int exp_dc,
                          input logic exp_e, input logic [15:0] exp_rd, input string nm);
        int  stalls;
        bit  seen;
        stalls = 0;
        seen   = 1'b0;
        rd_s[u] = rd; wrt_s[u] = wrt; byte_s[u] = byt;
        addr_s[u] = a; wdata_s[u] = wd;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge clk);
            if (done_s[u]) begin
                seen = 1'b1;
                chk($sformatf("%s done_cycle", nm), cyc, exp_dc);
                chk($sformatf("%s err", nm), {31'd0, err_s[u]}, {31'd0, exp_e});
                chk($sformatf("%s rdata", nm), {16'd0, rdata_s[u]}, {16'd0, exp_rd});
                chk($sformatf("%s stall_in_resp", nm), {31'd0, stall_s[u]}, 32'd0);
                chk($sformatf("%s stall_cycles", nm), stalls, exp_dc);
            end else if (stall_s[u]) begin
                stalls++;
            end
            @(posedge clk); #1;
            if (seen) begin
                rd_s[u] = 1'b0; wrt_s[u] = 1'b0; byte_s[u] = 1'b0;
            end
        end
        if (!seen) begin
            rd_s[u] = 1'b0; wrt_s[u] = 1'b0; byte_s[u] = 1'b0;
            chk($sformatf("%s timeout", nm), 32'd0, 32'd1);
        end
    endtask

    initial begin
        int          dc;
        logic        e;
        logic [15:0] rexp;

        for (int u = 0; u < NU; u++) begin
            rd_s[u] = 1'b0; wrt_s[u] = 1'b0; byte_s[u] = 1'b0;
            addr_s[u] = '0; wdata_s[u] = '0; last_m[u] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                known_m[u][i] = 1'b0;
                mem_m[u][i]   = '0;
            end
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("reset u%0d outs", u),
                {13'd0, done_s[u], err_s[u], stall_s[u], rdata_s[u]}, 32'd0);
        end
        @(posedge clk); #1;

        // {unit, rd, wrt, byte, addr, wdata, done_cycle, err, rdata}
        vecs.push_back('{0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 3, 1'b0, 16'h0000});
        vecs.push_back('{0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 3, 1'b0, 16'hBEEF});
        vecs.push_back('{0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h1111, 1, 1'b1, 16'h0000});
        vecs.push_back('{0, 1'b1, 1'b0, 1'b0, 16'h0011, 16'h0000, 1, 1'b1, 16'h0000});
        vecs.push_back('{0, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h2222, 1, 1'b1, 16'h0000});
        vecs.push_back('{0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 3, 1'b0, 16'hBEEF});
        vecs.push_back('{1, 1'b0, 1'b1, 1'b0, 16'h0002, 16'hA5A5, 2, 1'b0, 16'h0000});
        vecs.push_back('{1, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000, 2, 1'b0, 16'hA5A5});
        vecs.push_back('{1, 1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0000, 1, 1'b1, 16'h0000});
        vecs.push_back('{1, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 1, 1'b1, 16'h0000});
        vecs.push_back('{2, 1'b0, 1'b1, 1'b0, 16'h00FE, 16'h0F0F, 17, 1'b0, 16'h0000});
        vecs.push_back('{2, 1'b1, 1'b0, 1'b0, 16'h00FE, 16'h0000, 17, 1'b0, 16'h0F0F});

        for (int i = 0; i < vecs.size(); i++) begin
            model(vecs[i].u, vecs[i].rd, vecs[i].wrt, vecs[i].byt, vecs[i].a,
                  vecs[i].wd, dc, e, rexp);
            do_req(vecs[i].u, vecs[i].rd, vecs[i].wrt, vecs[i].byt, vecs[i].a,
                   vecs[i].wd, vecs[i].dc, vecs[i].e, vecs[i].rdat,
                   $sformatf("vec%0d", i));
        end

        // rdata holds after the response
        @(negedge clk);
        chk("hold done", {31'd0, done_s[2]}, 32'd0);
        chk("hold rdata", {16'd0, rdata_s[2]}, 32'h0F0F);
        @(posedge clk); #1;

        // Reset on the commit edge of a store aborts the write
        model(0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h5555, dc, e, rexp);
        do_req(0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h5555, 3, 1'b0, 16'hBEEF, "prior_store");
        rd_s[0] = 1'b0; wrt_s[0] = 1'b1; addr_s[0] = 16'h0020; wdata_s[0] = 16'h1234;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; wrt_s[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset outs", {13'd0, done_s[0], err_s[0], stall_s[0], rdata_s[0]}, 32'd0);
        for (int u = 0; u < NU; u++) last_m[u] = 16'h0000;
        @(posedge clk); #1;
        model(0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, dc, e, rexp);
        do_req(0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 3, 1'b0, 16'h5555, "after_abort");

`ifdef DMEM_BYTE_EN
        model(0, 1'b0, 1'b1, 1'b0, 16'h0004, 16'h1234, dc, e, rexp);
        do_req(0, 1'b0, 1'b1, 1'b0, 16'h0004, 16'h1234, 3, 1'b0, 16'h5555, "b_wst");
        model(0, 1'b0, 1'b1, 1'b1, 16'h0005, 16'hABFF, dc, e, rexp);
        do_req(0, 1'b0, 1'b1, 1'b1, 16'h0005, 16'hABFF, 3, 1'b0, 16'h5555, "b_bst");
        model(0, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, dc, e, rexp);
        do_req(0, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 3, 1'b0, 16'hFF34, "b_wld");
        model(0, 1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000, dc, e, rexp);
        do_req(0, 1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000, 3, 1'b0, 16'h0034, "b_bld");
`endif

        // Randomized traffic against the reference model
        for (int n = 0; n < 80; n++) begin
            int          u;
            int          k;
            int          r;
            int          w;
            logic        rd;
            logic        wrt;
            logic        byt;
            logic [15:0] a;
            logic [15:0] wd;
            u   = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            k   = int'($urandom_range(0, 9));
            r   = int'($urandom_range(0, 9));
            rd  = (k < 4) || (k == 9);
            wrt = (k >= 4);
            a   = 16'($urandom_range(0, 15) * 2);
            if (r == 0) a[0] = 1'b1;
            if (r == 1) a = 16'(256 + $urandom_range(0, 1000) * 2);
            wd  = 16'($urandom);
            byt = 1'b0;
`ifdef DMEM_BYTE_EN
            byt = ($urandom_range(0, 3) == 0);
`endif
            w = int'(a) / 2;
            if (!(rd && wrt) && (w < DEPTH) && (rd || byt) && !known_m[u][w]) begin
                rd = 1'b0; wrt = 1'b1; byt = 1'b0;
            end
            model(u, rd, wrt, byt, a, wd, dc, e, rexp);
            do_req(u, rd, wrt, byt, a, wd, dc, e, rexp, $sformatf("rnd%0d", n));
            repeat (int'($urandom_range(0, 2))) begin
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
